alu_mdu_ctrl: RTL

Parametrised successor to the execute-stage ALU control decoder. It keeps the combinational `{i_ALUOp, i_Funct3, i_Funct7}` → `o_ALUControlLines` decode for the base integer ALU. It adds RV32M/RV64M support by dispatching MUL/DIV/REM instructions to an internal iterative multiply/divide engine. It stalls the pipeline until the result is ready. It sits in EX, beside the ALU; the EX result mux selects `o_mdu_result` when `o_mdu_sel` = 1.

---
 rtl/alu_mdu_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_mdu_ctrl.sv
// alu_mdu_ctrl: EX-stage ALU control decoder with an iterative RV32M/RV64M
// multiply/divide engine.
//   i_clk, i_rst         : clock, synchronous active-high reset
//   i_valid, i_flush     : EX holds a valid instruction / abort in-flight op
//   i_Funct7/3, i_ALUOp  : instruction fields and main-decoder class
//   i_rs1, i_rs2         : operands
//   o_ALUControlLines    : ALU operation (combinational)
//   o_mdu_sel            : instruction is an M-extension op (combinational)
//   o_stall              : freeze IF/ID/EX (combinational)
//   o_mdu_done           : one-cycle pulse, o_mdu_result valid
//   o_mdu_result         : registered MDU result
module alu_mdu_ctrl #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ALUCTL_W = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  input  logic                i_flush,
  input  logic [6:0]          i_Funct7,
  input  logic [2:0]          i_Funct3,
  input  logic [1:0]          i_ALUOp,
  input  logic [XLEN-1:0]     i_rs1,
  input  logic [XLEN-1:0]     i_rs2,
  output logic [ALUCTL_W-1:0] o_ALUControlLines,
  output logic                o_mdu_sel,
  output logic                o_stall,
  output logic                o_mdu_done,
  output logic [XLEN-1:0]     o_mdu_result
);

  localparam int unsigned CNT_W = $clog2(XLEN + 1);

  localparam logic [3:0] CTL_AND  = 4'b0000;
  localparam logic [3:0] CTL_OR   = 4'b0001;
  localparam logic [3:0] CTL_ADD  = 4'b0010;
  localparam logic [3:0] CTL_XOR  = 4'b0011;
  localparam logic [3:0] CTL_SLL  = 4'b0100;
  localparam logic [3:0] CTL_SRL  = 4'b0101;
  localparam logic [3:0] CTL_SUB  = 4'b0110;
  localparam logic [3:0] CTL_SLT  = 4'b0111;
  localparam logic [3:0] CTL_SRA  = 4'b1000;
  localparam logic [3:0] CTL_SLTU = 4'b1001;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   opa_q;
  logic [XLEN-1:0]   acc_hi_q;
  logic [XLEN-1:0]   acc_lo_q;

  logic [3:0]        ctl;
  logic              is_mdu;
  logic              accept;

  // funct3 -> ALU op; alt selects the SUB/SRA variants
  function automatic logic [3:0] f3_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  f3_op = alt ? CTL_SUB : CTL_ADD;
      3'b001:  f3_op = CTL_SLL;
      3'b010:  f3_op = CTL_SLT;
      3'b011:  f3_op = CTL_SLTU;
      3'b100:  f3_op = CTL_XOR;
      3'b101:  f3_op = alt ? CTL_SRA : CTL_SRL;
      3'b110:  f3_op = CTL_OR;
      default: f3_op = CTL_AND;
    endcase
  endfunction

  assign is_mdu    = (i_ALUOp == 2'b10) && (i_Funct7 == 7'h01);
  assign o_mdu_sel = is_mdu;
  assign accept    = (state_q == S_IDLE) && i_valid && is_mdu && !i_flush;

  // Base ALU control decode
  always_comb begin
    ctl = CTL_ADD;
    case (i_ALUOp)
      2'b00: ctl = CTL_ADD;
      2'b01: ctl = CTL_SUB;
      2'b10: begin
        if (i_Funct7 == 7'h00)      ctl = f3_op(i_Funct3, 1'b0);
        else if (i_Funct7 == 7'h20) ctl = f3_op(i_Funct3, 1'b1);
        else                        ctl = CTL_ADD;
      end
      default: begin
        if (i_Funct3 == 3'b000) ctl = CTL_ADD;
        else                    ctl = f3_op(i_Funct3, i_Funct7 == 7'h20);
      end
    endcase
  end

  assign o_ALUControlLines = ALUCTL_W'(ctl);

  // Operand signedness and magnitudes for the incoming op
  logic            sgn1, sgn2, rs1_neg, rs2_neg;
  logic [XLEN-1:0] rs1_mag, rs2_mag;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_result;

  always_comb begin
    sgn1 = (i_Funct3 == 3'b001) || (i_Funct3 == 3'b010) ||
           (i_Funct3 == 3'b100) || (i_Funct3 == 3'b110);
    sgn2 = (i_Funct3 == 3'b001) || (i_Funct3 == 3'b100) || (i_Funct3 == 3'b110);
    rs1_neg = sgn1 && i_rs1[XLEN-1];
    rs2_neg = sgn2 && i_rs2[XLEN-1];
    rs1_mag = rs1_neg ? (-i_rs1) : i_rs1;
    rs2_mag = rs2_neg ? (-i_rs2) : i_rs2;
    div_zero = (i_rs2 == '0);
    div_ovf  = ((i_Funct3 == 3'b100) || (i_Funct3 == 3'b110)) &&
               (i_rs1 == MOST_NEG) && (i_rs2 == '1);
    fast     = i_Funct3[2] && (div_zero || div_ovf);
    // funct3[1] distinguishes REM/REMU from DIV/DIVU
    if (i_Funct3[1]) fast_result = div_zero ? i_rs1 : '0;
    else             fast_result = div_zero ? '1 : i_rs1;
  end

  // One radix-2 iteration: shift-add multiply or restoring divide
  logic [XLEN:0]     mul_sum, div_shift, div_trial;
  logic [XLEN-1:0]   hi_n, lo_n, div_res;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   iter_result;

  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opa_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
    div_trial = div_shift - {1'b0, opa_q};
    if (op_q[2]) begin
      // A failed trial leaves a partial remainder below the divisor, so the
      // top bit of div_shift is zero whenever it is kept.
      hi_n = div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
      lo_n = {acc_lo_q[XLEN-2:0], ~div_trial[XLEN]};
    end else begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], acc_lo_q[XLEN-1:1]};
    end
    prod    = {hi_n, lo_n};
    prod_s  = neg_q ? (-prod) : prod;
    div_res = op_q[1] ? hi_n : lo_n;
    div_res = neg_q ? (-div_res) : div_res;
    if (op_q[2])              iter_result = div_res;
    else if (op_q == 3'b000)  iter_result = prod_s[XLEN-1:0];
    else                      iter_result = prod_s[2*XLEN-1:XLEN];
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = fast ? S_DONE : S_BUSY;
      S_BUSY: begin
        if (i_flush)                  state_d = S_IDLE;
        else if (cnt_q == CNT_W'(1))  state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_stall    = 1'b0;
    o_mdu_done = 1'b0;
    case (state_q)
      S_IDLE:  o_stall    = i_valid && is_mdu;
      S_BUSY:  o_stall    = 1'b1;
      S_DONE:  o_mdu_done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand latch, iteration, result write
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q        <= '0;
      op_q         <= '0;
      neg_q        <= 1'b0;
      opa_q        <= '0;
      acc_hi_q     <= '0;
      acc_lo_q     <= '0;
      o_mdu_result <= '0;
    end else if (accept) begin
      op_q     <= i_Funct3;
      neg_q    <= (i_Funct3[2] && i_Funct3[1]) ? rs1_neg : (rs1_neg ^ rs2_neg);
      opa_q    <= i_Funct3[2] ? rs2_mag : rs1_mag;
      acc_lo_q <= i_Funct3[2] ? rs1_mag : rs2_mag;
      acc_hi_q <= '0;
      if (fast) begin
        cnt_q        <= '0;
        o_mdu_result <= fast_result;
      end else begin
        cnt_q <= CNT_W'(XLEN);
      end
    end else if (state_q == S_BUSY) begin
      if (i_flush) begin
        cnt_q <= '0;
      end else begin
        acc_hi_q <= hi_n;
        acc_lo_q <= lo_n;
        cnt_q    <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) o_mdu_result <= iter_result;
      end
    end
  end

endmodule
